// File: rtl/etch_pkg.sv
// Shared types and constants for the etch-a-sketch front-panel logic.
package etch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Bit positions inside the direction vector {up, down, left, right}
    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;
    localparam int unsigned DIR_W     = 4;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: compares the input with its registered previous level.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next value of the previous-level register
    always_comb begin
        prev_d = in;
    end

    // Previous-level register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // The consumer registers this pulse, so the input-to-output latency stays one clock
    assign rise = in & ~prev_q;

endmodule

// File: rtl/cursor_controller.sv
// Turns debounced direction/draw button levels into a saturating cursor position,
// a move pulse and a draw-enable toggle. Held directions auto-repeat.
module cursor_controller #(
    parameter int unsigned WIDTH        = 240,
    parameter int unsigned HEIGHT       = 320,
    parameter int unsigned HOLD_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up,
    input  logic                      down,
    input  logic                      left,
    input  logic                      right,
    input  logic                      draw_toggle,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      moved,
    output logic                      draw_en
);

    import etch_pkg::*;

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned CW = $clog2(HOLD_TICKS);

    if (HOLD_TICKS < 2 || REPEAT_TICKS < 1 || REPEAT_TICKS > HOLD_TICKS) begin : g_param_check
        $error("cursor_controller: need HOLD_TICKS >= 2 and 1 <= REPEAT_TICKS <= HOLD_TICKS");
    end

    // Saturating +/-1 step; inc and dec are never both set after axis cancellation
    function automatic int unsigned sat_step(input int unsigned pos, input logic inc,
                                             input logic dec, input int unsigned max_pos);
        if (inc && pos < max_pos) begin
            return pos + 1;
        end else if (dec && pos > 0) begin
            return pos - 1;
        end
        return pos;
    endfunction

    logic [DIR_W-1:0] dir;
    logic [DIR_W-1:0] eff;
    logic [DIR_W-1:0] prev_eff_q;
    logic             press;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_move;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             moved_q, moved_d;
    logic             draw_en_q, draw_en_d;
    logic             draw_rise;

    assign dir = {up, down, left, right};

    // Cancel an axis whose two opposing buttons are both held, then detect press events
    always_comb begin
        eff = dir;
        if (dir[DIR_UP] && dir[DIR_DOWN]) begin
            eff[DIR_UP]   = 1'b0;
            eff[DIR_DOWN] = 1'b0;
        end
        if (dir[DIR_LEFT] && dir[DIR_RIGHT]) begin
            eff[DIR_LEFT]  = 1'b0;
            eff[DIR_RIGHT] = 1'b0;
        end
        press = (eff != '0) && (eff != prev_eff_q);
    end

    // Hold / auto-repeat FSM: next state, tick counter and move request
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        do_move = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    do_move = 1'b1;
                    count_d = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (eff == '0) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (press) begin
                    do_move = 1'b1;
                    count_d = '0;
                end else if (count_q == CW'(HOLD_TICKS - 1)) begin
                    do_move = 1'b1;
                    count_d = '0;
                    state_d = S_REPEAT;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_REPEAT: begin
                if (eff == '0) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (press) begin
                    do_move = 1'b1;
                    count_d = '0;
                    state_d = S_HOLD;
                end else if (count_q == CW'(REPEAT_TICKS - 1)) begin
                    do_move = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Apply a requested move to both axes; pulse moved only if the cursor really changed
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (do_move) begin
            x_d = XW'(sat_step(32'(x_q), eff[DIR_RIGHT], eff[DIR_LEFT], WIDTH - 1));
            y_d = YW'(sat_step(32'(y_q), eff[DIR_DOWN], eff[DIR_UP], HEIGHT - 1));
        end
        moved_d   = do_move && ((x_d != x_q) || (y_d != y_q));
        draw_en_d = draw_en_q ^ draw_rise;
    end

    edge_detector u_draw_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (draw_toggle),
        .rise (draw_rise)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            prev_eff_q <= '0;
            x_q        <= XW'(WIDTH / 2);
            y_q        <= YW'(HEIGHT / 2);
            moved_q    <= 1'b0;
            draw_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prev_eff_q <= eff;
            x_q        <= x_d;
            y_q        <= y_d;
            moved_q    <= moved_d;
            draw_en_q  <= draw_en_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign moved   = moved_q;
    assign draw_en = draw_en_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Scoreboard bench for cursor_controller on an 8x8 screen with short hold/repeat delays.
module tb_cursor_controller;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 8;
    localparam int unsigned HT = 5;
    localparam int unsigned RT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, draw_toggle = 1'b0;
    logic [2:0] x;
    logic [2:0] y;
    logic       moved;
    logic       draw_en;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       moved;
        logic       draw_en;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    cursor_controller #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .HOLD_TICKS   (HT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .draw_toggle (draw_toggle),
        .x           (x),
        .y           (y),
        .moved       (moved),
        .draw_en     (draw_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got time=%0t want done", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic u, input logic d, input logic l, input logic r,
                          input logic dt);
        up = u; down = d; left = l; right = r; draw_toggle = dt;
    endtask

    task automatic push_exp(input int ex, input int ey, input logic em, input logic ed);
        exp_t t;
        t.x = 3'(ex); t.y = 3'(ey); t.moved = em; t.draw_en = ed;
        sb_q.push_back(t);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        push_exp(4, 4, 0, 0);
        #1;
        e = sb_q.pop_front();
        total++;
        if ({x, y, moved, draw_en} !== e) begin
            bad++;
            $display("FAIL reset_immediate: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                     x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(4, 4, 0, 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
    endtask

    task automatic test_single_tap();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            set_in(0, 0, 0, i == 0, 0);
            push_exp(5, 4, i == 0, 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL single_tap cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
    endtask

    task automatic test_hold_repeat();
        int ex;
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            set_in(0, 0, 0, k < 12, 0);
            // Moves land on edges 0, 5 and 7; edges 9 and 11 hit the right edge
            ex = (k < 5) ? 5 : (k < 7) ? 6 : 7;
            push_exp(ex, 4, (k == 0) || (k == 5) || (k == 7), 0);
            @(posedge clk); #1;
            if (moved === 1'b1) pulses++;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL hold_repeat edge=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         k, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL hold_repeat_pulses: got %0d want 3", pulses);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        // up+down cancel, left survives
        for (int i = 0; i < 2; i++) begin
            set_in(i == 0, i == 0, i == 0, 0, 0);
            push_exp(3, 4, i == 0, 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL cancel_diag cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_in(i < 3, i < 3, 0, 0, 0);
            push_exp(3, 4, 0, 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL cancel_updown cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
    endtask

    task automatic test_draw();
        logic dt;
        logic rt;
        logic exp_de;
        int   ex;
        do_reset();
        // cycles 0-9 draw held, 12 second press, 15 draw + right together
        for (int i = 0; i < 17; i++) begin
            dt = (i < 10) || (i == 12) || (i == 15);
            rt = (i == 15);
            set_in(0, 0, 0, rt, dt);
            exp_de = (i < 12) ? 1'b1 : (i < 15) ? 1'b0 : 1'b1;
            ex = (i < 15) ? 4 : 5;
            push_exp(ex, 4, i == 15, exp_de);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL draw cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        int ex;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            set_in(0, 0, 1, 0, 0);
            ex = (k < 5) ? 3 : (k < 7) ? 2 : 1;
            push_exp(ex, 4, (k == 0) || (k == 5) || (k == 7), 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL pre_reset_left edge=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         k, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
        // Assert reset between edges with left still held
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_exp(4, 4, 0, 0);
            if (i == 0) begin
                #1;
            end else begin
                @(posedge clk); #1;
            end
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL mid_reset cyc=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         i, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            push_exp((j < 5) ? 3 : 2, 4, (j == 0) || (j == 5), 0);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({x, y, moved, draw_en} !== e) begin
                bad++;
                $display("FAIL post_reset_left edge=%0d: got x=%0d y=%0d moved=%0b draw_en=%0b want x=%0d y=%0d moved=%0b draw_en=%0b",
                         j, x, y, moved, draw_en, e.x, e.y, e.moved, e.draw_en);
            end
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_hold_repeat();
        test_cancel();
        test_draw();
        test_reset_mid_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
